// File: rtl/tone_pkg.sv
// Shared definitions for the tone sequencer: FSM encoding, note byte layout
// and the pitch-to-divide table.
package tone_pkg;

   typedef enum logic [1:0] {S_IDLE, S_LOAD, S_PLAY, S_GAP} state_t;

   localparam int PITCH_MSB = 7;
   localparam int PITCH_LSB = 4;
   localparam int DUR_MSB   = 3;
   localparam int DUR_LSB   = 0;

   localparam logic [31:0] DIV_RESET = 32'd2;

   // Rounded CLK_HZ / f, with f given in centihertz.
   function automatic logic [31:0] div_round(input longint hz, input longint f_chz);
      return 32'((hz * 100 + f_chz / 2) / f_chz);
   endfunction

   function automatic logic is_tone(input logic [3:0] pitch);
      return (pitch >= 4'd1) && (pitch <= 4'd12);
   endfunction

   // Each branch is constant once hz is a parameter, so this folds to a ROM.
   function automatic logic [31:0] pitch_div(input logic [3:0] pitch, input longint hz);
      case (pitch)
         4'd1:    return div_round(hz, 26163);  // C4
         4'd2:    return div_round(hz, 27718);  // C#4
         4'd3:    return div_round(hz, 29366);  // D4
         4'd4:    return div_round(hz, 31113);  // D#4
         4'd5:    return div_round(hz, 32963);  // E4
         4'd6:    return div_round(hz, 34923);  // F4
         4'd7:    return div_round(hz, 36999);  // F#4
         4'd8:    return div_round(hz, 39200);  // G4
         4'd9:    return div_round(hz, 41530);  // G#4
         4'd10:   return div_round(hz, 44000);  // A4
         4'd11:   return div_round(hz, 46616);  // A#4
         4'd12:   return div_round(hz, 49388);  // B4
         default: return DIV_RESET;
      endcase
   endfunction

endpackage

// File: rtl/note_fifo.sv
// Synchronous note queue; a push on full is taken when a pop happens in the
// same cycle, and flush overrides both.
module note_fifo #(
   parameter int DEPTH = 8,
   parameter int W     = 8
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         push,
   input  logic         pop,
   input  logic         flush,
   input  logic [W-1:0] wr_data,
   output logic [W-1:0] rd_data,
   output logic         full,
   output logic         empty
);

   localparam int AW = $clog2(DEPTH);

   logic [W-1:0]  mem [DEPTH];
   logic [AW-1:0] wr_ptr, rd_ptr;
   logic [AW:0]   count;
   logic          do_push, do_pop;

   assign empty   = (count == '0);
   assign full    = (count == (AW+1)'(DEPTH));
   assign do_pop  = pop && !empty && !flush;
   assign do_push = push && (!full || do_pop) && !flush;
   assign rd_data = mem[rd_ptr];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + AW'(1);
         if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
         case ({do_push, do_pop})
            2'b10:   count <= count + (AW+1)'(1);
            2'b01:   count <= count - (AW+1)'(1);
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= wr_data;
   end

endmodule

// File: rtl/tone_sequencer.sv
// Plays queued note bytes as a divide ratio plus tone enable, with a silent
// articulation gap after every note.
module tone_sequencer
   import tone_pkg::*;
#(
   parameter int CLK_HZ      = 12000000,
   parameter int BEAT_CYCLES = 1500000,
   parameter int GAP_CYCLES  = 120000,
   parameter int FIFO_DEPTH  = 8
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        note_valid,
   input  logic [7:0]  note_data,
   output logic        note_ready,
   input  logic        flush,
   output logic [31:0] div,
   output logic        tone_on,
   output logic        busy
);

   localparam int CW = $clog2(BEAT_CYCLES + 1);
   localparam int GW = $clog2(GAP_CYCLES + 1);

   state_t        state, state_n;
   logic [7:0]    head;
   logic          full, empty, pop;
   logic [3:0]    pitch, dur;
   logic [3:0]    beat_cnt;
   logic [CW-1:0] cycle_cnt;
   logic [GW-1:0] gap_cnt;
   logic          last_cycle;

   assign pitch      = head[PITCH_MSB:PITCH_LSB];
   assign dur        = head[DUR_MSB:DUR_LSB];
   assign pop        = (state == S_LOAD) && !flush;
   assign note_ready = !full;
   assign busy       = (state != S_IDLE) || !empty;
   assign last_cycle = (cycle_cnt == '0) && (beat_cnt == 4'd1);

   note_fifo #(.DEPTH(FIFO_DEPTH), .W(8)) u_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .push    (note_valid),
      .pop     (pop),
      .flush   (flush),
      .wr_data (note_data),
      .rd_data (head),
      .full    (full),
      .empty   (empty)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= S_IDLE;
      else        state <= state_n;
   end

   always_comb begin
      state_n = state;
      case (state)
         S_IDLE: if (!empty) state_n = S_LOAD;
         // zero-length notes are dropped and re-enter via IDLE
         S_LOAD: state_n = (dur == 4'd0) ? S_IDLE : S_PLAY;
         S_PLAY: if (last_cycle) state_n = S_GAP;
         S_GAP:  if (gap_cnt == '0) state_n = empty ? S_IDLE : S_LOAD;
         default: state_n = S_IDLE;
      endcase
      if (flush) state_n = S_IDLE;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         div       <= DIV_RESET;
         tone_on   <= 1'b0;
         beat_cnt  <= '0;
         cycle_cnt <= '0;
         gap_cnt   <= '0;
      end else if (flush) begin
         tone_on   <= 1'b0;
         beat_cnt  <= '0;
         cycle_cnt <= '0;
         gap_cnt   <= '0;
      end else begin
         case (state)
            S_LOAD: if (dur != 4'd0) begin
               beat_cnt  <= dur;
               cycle_cnt <= CW'(BEAT_CYCLES - 1);
               tone_on   <= is_tone(pitch);
               // rests keep the previous divide so div never drops to 0/1
               if (is_tone(pitch)) div <= pitch_div(pitch, longint'(CLK_HZ));
            end
            S_PLAY: begin
               if (cycle_cnt != '0) begin
                  cycle_cnt <= cycle_cnt - CW'(1);
               end else if (beat_cnt == 4'd1) begin
                  tone_on <= 1'b0;
                  gap_cnt <= GW'(GAP_CYCLES - 1);
               end else begin
                  beat_cnt  <= beat_cnt - 4'd1;
                  cycle_cnt <= CW'(BEAT_CYCLES - 1);
               end
            end
            S_GAP: if (gap_cnt != '0) gap_cnt <= gap_cnt - GW'(1);
            default: ;
         endcase
      end
   end

endmodule
